// File: rtl/mult_share_arb.sv
// Round-robin arbiter that shares one booth_mult among NREQ requesters.
// Optional watchdog on mult_done is enabled by defining MULT_SHARE_ARB_TIMEOUT_EN.
module mult_share_arb #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_m,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mult_en,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic                  mult_done,
    input  logic [2*WIDTH-1:0]    mult_m
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_r;
`endif

    logic [1:0]     state_r;
    logic [IDW-1:0] last_r;
    logic [IDW-1:0] cur_id_r;
    logic           found_s;
    logic [IDW-1:0] sel_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found_s && req[(int'(last_r) + i) % NREQ]) begin
                found_s = 1'b1;
                sel_s   = IDW'((int'(last_r) + i) % NREQ);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Sequencer FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            last_r    <= IDW'(NREQ - 1);
            cur_id_r  <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_m     <= '0;
            rsp_id    <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mult_en   <= 1'b0;
            mult_a    <= '0;
            mult_b    <= '0;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        mult_a   <= req_a[int'(sel_s)*WIDTH +: WIDTH];
                        mult_b   <= req_b[int'(sel_s)*WIDTH +: WIDTH];
                        mult_en  <= 1'b1;
                        gnt      <= NREQ'(1'b1) << sel_s;
                        cur_id_r <= sel_s;
                        last_r   <= sel_s;
                        busy     <= 1'b1;
                        state_r  <= ST_BUSY;
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                        tmo_cnt_r <= '0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // A done that coincides with the final watchdog count still wins.
                    if (mult_done) begin
                        rsp_m     <= mult_m;
                        rsp_id    <= cur_id_r;
                        rsp_valid <= NREQ'(1'b1) << cur_id_r;
                        mult_en   <= 1'b0;
                        state_r   <= ST_GAP;
                    end
`ifdef MULT_SHARE_ARB_TIMEOUT_EN
                    else if (tmo_cnt_r == TW'(TIMEOUT - 1)) begin
                        rsp_err <= 1'b1;
                        rsp_id  <= cur_id_r;
                        mult_en <= 1'b0;
                        state_r <= ST_GAP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
`else
                    else begin
                        mult_en <= 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    // One idle cycle with en low lets booth_mult re-arm.
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mult_en <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb with a behavioural booth_mult stand-in.
// Timeout scenario runs only when MULT_SHARE_ARB_TIMEOUT_EN is defined.
module tb_mult_share_arb;
    localparam int W    = 8;
    localparam int N    = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic [N-1:0]       gnt;
    logic [N-1:0]       rsp_valid;
    logic [2*W-1:0]     rsp_m;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_err;
    logic               busy;
    logic               mult_en;
    logic [W-1:0]       mult_a;
    logic [W-1:0]       mult_b;
    logic               mult_done;
    logic [2*W-1:0]     mult_m;

    mult_share_arb #(.WIDTH(W), .NREQ(N), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_m(rsp_m), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .busy(busy), .mult_en(mult_en), .mult_a(mult_a),
        .mult_b(mult_b), .mult_done(mult_done), .mult_m(mult_m)
    );

    always #5 clk = ~clk;

    // booth_mult stand-in: fixed latency, done held until en drops
    logic       kill = 1'b0;
    logic [3:0] mcnt = 4'd0;
    logic       mdone = 1'b0;
    logic [15:0] mm = 16'd0;
    assign mult_done = mdone;
    assign mult_m    = mm;
    always @(posedge clk) begin
        if (!mult_en) begin
            mdone <= 1'b0;
            mcnt  <= 4'd0;
        end else if (!mdone && !kill) begin
            if (mcnt == 4'(LAT - 1)) begin
                mdone <= 1'b1;
                mm    <= {{8{mult_a[7]}}, mult_a} * {{8{mult_b[7]}}, mult_b};
            end else begin
                mcnt <= mcnt + 4'd1;
            end
        end
    end

    typedef struct { int id; logic [7:0] a; logic [7:0] b; } gnt_t;
    typedef struct { int id; logic [15:0] m; } rsp_t;
    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    int   exp_err[$];

    int checks = 0;
    int errors = 0;
    int grant_cnt = 0;
    int left[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Grant monitor: order, one-hot and operands presented to the multiplier
    initial begin
        forever begin
            @(negedge clk);
            if (gnt != '0) begin
                if (exp_gnt.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    gnt_t g;
                    g = exp_gnt.pop_front();
                    chk("gnt_onehot", 32'(gnt), 32'd1 << g.id);
                    chk("gnt_mult_a", 32'(mult_a), 32'(g.a));
                    chk("gnt_mult_b", 32'(mult_b), 32'(g.b));
                    chk("gnt_mult_en", 32'(mult_en), 32'd1);
                end
            end
        end
    end

    // Response monitor: product, id, one-hot valid and the single GAP cycle
    initial begin
        bit gap_pend;
        gap_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (gap_pend) begin
                chk("gap_one_cycle_busy", 32'(busy), 32'd0);
                gap_pend = 1'b0;
            end
            if (rsp_valid != '0) begin
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    rsp_t r;
                    r = exp_rsp.pop_front();
                    chk("rsp_valid_onehot", 32'(rsp_valid), 32'd1 << r.id);
                    chk("rsp_id", 32'(rsp_id), 32'(r.id));
                    chk("rsp_m", 32'(rsp_m), 32'(r.m));
                    chk("gap_en_low", 32'({mult_en, busy}), 32'b01);
                    gap_pend = 1'b1;
                end
            end
            if (rsp_err) begin
                if (exp_err.size() == 0) begin
                    chk("err_unexpected", 32'(rsp_err), 32'd0);
                end else begin
                    int e;
                    e = exp_err.pop_front();
                    chk("err_id", 32'(rsp_id), 32'(e));
                    chk("err_no_valid", 32'(rsp_valid), 32'd0);
                end
            end
        end
    end

    // Advance one cycle; requesters drop req after their last grant
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                grant_cnt++;
                left[k] = left[k] - 1;
                if (left[k] <= 0) req[k] = 1'b0;
            end
        end
    endtask

    task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input int cnt);
        req_a[k*W +: W] = a;
        req_b[k*W +: W] = b;
        left[k] = cnt;
        req[k] = 1'b1;
    endtask

    task automatic expect_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic [15:0] m);
        gnt_t g;
        rsp_t r;
        g.id = k; g.a = a; g.b = b;
        r.id = k; r.m = m;
        exp_gnt.push_back(g);
        exp_rsp.push_back(r);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_gnt.size() != 0 || exp_rsp.size() != 0 || busy || req != '0) && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int n;
        int cyc;
        rst = 1'b1;
        req = '0;
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < N; k++) left[k] = 0;
        step();
        step();
        chk("reset_outputs", 32'({gnt, rsp_valid, rsp_err, busy, mult_en}), 32'd0);
        chk("reset_data", 32'({mult_a, mult_b, rsp_m[7:0], rsp_id}), 32'd0);
        chk("reset_rsp_m", 32'(rsp_m), 32'd0);
        rst = 1'b0;
        step();

        // single request: -10 * -100
        expect_op(0, 8'hF6, 8'h9C, 16'd1000);
        issue(0, 8'hF6, 8'h9C, 1);
        drain("single_done");

        // extremes on requester 1
        expect_op(1, 8'h80, 8'h80, 16'd16384);
        issue(1, 8'h80, 8'h80, 1);
        drain("ext1_done");
        expect_op(1, 8'h80, 8'h7F, 16'hC080);
        issue(1, 8'h80, 8'h7F, 1);
        drain("ext2_done");

        // contention after reset: pointer restored so order is 0,1,2,3
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_op(0, 8'd3, 8'd5, 16'd15);
        expect_op(1, 8'hF9, 8'd9, 16'hFFC1);
        expect_op(2, 8'h7F, 8'h7F, 16'd16129);
        expect_op(3, 8'hFF, 8'h80, 16'd128);
        issue(0, 8'd3, 8'd5, 1);
        issue(1, 8'hF9, 8'd9, 1);
        issue(2, 8'h7F, 8'h7F, 1);
        issue(3, 8'hFF, 8'h80, 1);
        drain("contention_done");

        // fairness: 0 and 2 held, 1 joins once pointer sits at 0
        expect_op(0, 8'd2, 8'hFD, 16'hFFFA);
        expect_op(2, 8'hFB, 8'hFB, 16'd25);
        expect_op(0, 8'd2, 8'hFD, 16'hFFFA);
        expect_op(1, 8'd11, 8'd11, 16'd121);
        expect_op(2, 8'hFB, 8'hFB, 16'd25);
        expect_op(0, 8'd2, 8'hFD, 16'hFFFA);
        n = grant_cnt;
        issue(0, 8'd2, 8'hFD, 3);
        issue(2, 8'hFB, 8'hFB, 2);
        cyc = 0;
        while (grant_cnt < n + 3 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("fair_third_grant", 32'(cyc < 200), 32'd1);
        issue(1, 8'd11, 8'd11, 1);
        drain("fairness_done");

        // reset three cycles after gnt[2] aborts the operation
        begin
            gnt_t g;
            g.id = 2; g.a = 8'd4; g.b = 8'd4;
            exp_gnt.push_back(g);
        end
        issue(2, 8'd4, 8'd4, 1);
        cyc = 0;
        while (!gnt[2] && cyc < 50) begin
            step();
            cyc++;
        end
        chk("abort_gnt_seen", 32'(gnt[2]), 32'd1);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_en_busy", 32'({mult_en, busy, rsp_valid}), 32'd0);
        for (int i = 0; i < 12; i++) step();
        expect_op(0, 8'd6, 8'hF9, 16'hFFD6);
        issue(0, 8'd6, 8'hF9, 1);
        drain("after_abort_done");

`ifdef MULT_SHARE_ARB_TIMEOUT_EN
        // watchdog: done never arrives for requester 1
        kill = 1'b1;
        begin
            gnt_t g;
            g.id = 1; g.a = 8'd1; g.b = 8'd1;
            exp_gnt.push_back(g);
        end
        exp_err.push_back(1);
        issue(1, 8'd1, 8'd1, 1);
        cyc = 0;
        while (!gnt[1] && cyc < 50) begin
            step();
            cyc++;
        end
        n = 0;
        cyc = 0;
        while (!rsp_err && cyc < 200) begin
            if (mult_en) n++;
            step();
            cyc++;
        end
        chk("timeout_busy_cycles", 32'(n), 32'd64);
        kill = 1'b0;
        expect_op(3, 8'd2, 8'd2, 16'd4);
        issue(3, 8'd2, 8'd2, 1);
        drain("after_timeout_done");
        chk("err_queue_empty", 32'(exp_err.size()), 32'd0);
`endif

        for (int i = 0; i < 4; i++) step();
        chk("gnt_queue_empty", 32'(exp_gnt.size()), 32'd0);
        chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one booth_mult instance among NREQ requesters.
- Accepts one operand pair at a time and drives booth_mult's en/A/B handshake.
- Waits for done, then returns M to the granted requester.
- Sits between the requesting datapath blocks and the single booth_mult in the multiplier subsystem.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH, signed two's complement.
- NREQ, 4, number of requesters (2..8); IDW = $clog2(NREQ) is a localparam.
- TIMEOUT, 64, max cycles waiting for mult_done; used only with MULT_SHARE_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request; held high with stable operands until gnt seen.
- req_a  in  NREQ*WIDTH  packed signed multiplicands; requester k uses slice [k*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed signed multipliers, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester accepted.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: rsp_m valid for that requester.
- rsp_m  out  2*WIDTH  signed product, held until the next response.
- rsp_id  out  IDW  index of the last responded requester.
- rsp_err  out  1  timeout pulse; constant 0 without the macro.
- busy  out  1  high in BUSY and GAP states.
- mult_en  out  1  to booth_mult en.
- mult_a  out  WIDTH  to booth_mult A.
- mult_b  out  WIDTH  to booth_mult B.
- mult_done  in  1  from booth_mult done.
- mult_m  in  2*WIDTH  from booth_mult M.

Behaviour:
- Clock and reset: one clock; synchronous active-high reset rst, sampled on posedge clk. All outputs are registered.
- Reset values: gnt, rsp_valid, rsp_m, rsp_id, rsp_err, busy, mult_en, mult_a, mult_b all 0. State is IDLE. Round-robin pointer last = NREQ-1, so requester 0 has priority first.
- FSM states: IDLE, BUSY, GAP.
- IDLE, some req bit set:
  - Select k = first set req bit searching last+1, last+2, ... with wrap modulo NREQ.
  - At the edge: mult_a/mult_b <= requester k's operand slices; mult_en <= 1; gnt[k] <= 1 for exactly one cycle; cur_id <= k; last <= k; state <= BUSY.
- IDLE, no request: all pulses 0, stay in IDLE.
- BUSY:
  - mult_en stays 1; mult_a/mult_b stay stable.
  - On mult_done = 1: rsp_m <= mult_m; rsp_id <= cur_id; rsp_valid[cur_id] <= 1 (one cycle); mult_en <= 0; state <= GAP.
- GAP: exactly one cycle with mult_en = 0 so booth_mult re-arms; then state <= IDLE.
- Latency: grant-to-response = booth_mult latency + 1. Minimum spacing between grants = multiplier latency + 3 cycles.
- Requests during BUSY or GAP are ignored and must be held by the requester; they are never lost or queued twice.
- A requester dropping req before its grant is simply not selected.
- mult_done in IDLE or GAP is ignored.
- Arithmetic: no extension or truncation; operands pass through unchanged and mult_m is passed unmodified.
- Reset mid-operation: rst in BUSY or GAP aborts the operation. Next cycle mult_en = 0, state IDLE, no rsp_valid for the aborted op, pointer restored to NREQ-1.
- Simultaneous gnt and req change: requester k must sample gnt[k] and drop or replace its request at that edge. A req[k] still high in the gnt cycle is not re-granted, because state is BUSY.

Optional Feature:
- Macro: MULT_SHARE_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT without mult_done: mult_en <= 0, rsp_err <= 1 (one cycle), rsp_id <= cur_id, rsp_valid stays 0, rsp_m unchanged, state <= GAP.
  - mult_done arriving in the same cycle as the TIMEOUT count wins: normal response, no error.
- Undefined: no counter; BUSY waits indefinitely; rsp_err tied to 0.

Test Plan:
- Single request: req[0]=1, A=-10, B=-100 -> gnt[0] pulse, then rsp_valid[0] with rsp_m=1000, rsp_id=0; mult_en low exactly one GAP cycle.
- Extremes: req[1] with -128*-128 -> rsp_m=16384; then req[1] with -128*127 -> rsp_m=-16256.
- Contention: req[3:0]=4'b1111 held, each requester dropping req after its gnt -> grant order 0,1,2,3. Products checked against A*B per requester; no duplicate grants.
- Fairness: req[0] and req[2] continuously high with re-arm -> grants alternate 0,2,0,2; req[1] raised later is served before 0 repeats when the pointer is at 0.
- Reset mid-op: assert rst 3 cycles after gnt[2] -> next cycle mult_en=0, busy=0, no rsp_valid[2]. A new req[0] afterward completes correctly.
- Timeout (macro defined, TIMEOUT=64): mult_done tied 0, req[1] -> exactly 64 BUSY cycles, then rsp_err pulse with rsp_id=1, rsp_valid=0. The arbiter then grants the next request.
